// File: rtl/truth_table_sweep.sv
// Sweeps {w,x,y,z} through 0..15, samples f after SETTLE cycles per combination,
// and builds a 16-bit truth table plus minterm count. Optional compare: TT_SWEEP_CMP_EN.
module truth_table_sweep #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        f,
   output logic        w,
   output logic        x,
   output logic        y,
   output logic        z,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt,
   output logic [4:0]  ones
`ifdef TT_SWEEP_CMP_EN
   ,
   input  logic [15:0] expected,
   output logic [15:0] mismatch,
   output logic        pass
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

   state_t     state, state_next;
   logic [3:0] idx;
   logic [7:0] cnt;
   logic       accept;
   logic       sample;
   logic       last;

   assign accept = (state == ST_IDLE) && start;
   assign sample = (state == ST_SETTLE) && (cnt == CNT_LAST);
   assign last   = sample && (idx == 4'd15);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (start) state_next = ST_SETTLE;
         ST_SETTLE: if (last)  state_next = ST_DONE;
         ST_DONE:              state_next = ST_IDLE;
         default:              state_next = ST_IDLE;
      endcase
   end

   // idx is left at 15 after a sweep, so w..z hold 4'b1111 until the next start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx  <= '0;
         cnt  <= '0;
         tt   <= '0;
         ones <= '0;
      end else if (accept) begin
         idx  <= '0;
         cnt  <= '0;
         tt   <= '0;
         ones <= '0;
      end else if (state == ST_SETTLE) begin
         if (sample) begin
            tt[idx] <= f;
            ones    <= ones + 5'(f);
            cnt     <= '0;
            if (idx != 4'd15) idx <= idx + 4'd1;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

`ifdef TT_SWEEP_CMP_EN
   // The last sample lands in tt on the same edge, so f stands in for tt[15]
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch <= '0;
         pass     <= 1'b0;
      end else if (accept) begin
         mismatch <= '0;
         pass     <= 1'b0;
      end else if (last) begin
         mismatch <= {f, tt[14:0]} ^ expected;
         pass     <= (({f, tt[14:0]} ^ expected) == 16'h0000);
      end
   end
`endif

   assign {w, x, y, z} = idx;
   assign busy         = (state == ST_SETTLE);
   assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_truth_table_sweep.sv
// Scoreboard bench for truth_table_sweep: stimulus pushes expected results,
// per-DUT monitors pop and compare on each done pulse.
module tb_truth_table_sweep;

   typedef struct {
      logic [15:0] tt;
      logic [4:0]  ones;
      int unsigned cyc;
      logic [15:0] mm;
      logic        pass;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   logic        rst_n, start_a, start_b, f_a, f_b;
   logic [2:0]  mode;
   logic        w_a, x_a, y_a, z_a, busy_a, done_a;
   logic        w_b, x_b, y_b, z_b, busy_b, done_b;
   logic [15:0] tt_a, tt_b;
   logic [4:0]  ones_a, ones_b;
`ifdef TT_SWEEP_CMP_EN
   logic [15:0] expected_a, expected_b, mismatch_a, mismatch_b;
   logic        pass_a, pass_b;
`endif

   exp_t q_a[$];
   exp_t q_b[$];

   always_comb begin
      case (mode)
         3'd0:    f_a = w_a & x_a;
         3'd1:    f_a = 1'b1;
         3'd2:    f_a = 1'b0;
         3'd3:    f_a = ~w_a;
         3'd4:    f_a = x_a ^ z_a;
         default: f_a = 1'b0;
      endcase
   end
   assign f_b = z_b;

   truth_table_sweep #(.SETTLE(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .f(f_a),
      .w(w_a), .x(x_a), .y(y_a), .z(z_a), .busy(busy_a), .done(done_a),
      .tt(tt_a), .ones(ones_a)
`ifdef TT_SWEEP_CMP_EN
      , .expected(expected_a), .mismatch(mismatch_a), .pass(pass_a)
`endif
   );

   truth_table_sweep #(.SETTLE(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .f(f_b),
      .w(w_b), .x(x_b), .y(y_b), .z(z_b), .busy(busy_b), .done(done_b),
      .tt(tt_b), .ones(ones_b)
`ifdef TT_SWEEP_CMP_EN
      , .expected(expected_b), .mismatch(mismatch_b), .pass(pass_b)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (done_a) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q_a.pop_front();
            check("a_tt", 32'(tt_a), 32'(e.tt));
            check("a_ones", 32'(ones_a), 32'(e.ones));
            check("a_done_cycle", cyc, e.cyc);
            check("a_busy_in_done", 32'(busy_a), 32'd0);
`ifdef TT_SWEEP_CMP_EN
            check("a_mismatch", 32'(mismatch_a), 32'(e.mm));
            check("a_pass", 32'(pass_a), 32'(e.pass));
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (done_b) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q_b.pop_front();
            check("b_tt", 32'(tt_b), 32'(e.tt));
            check("b_ones", 32'(ones_b), 32'(e.ones));
            check("b_done_cycle", cyc, e.cyc);
         end
      end
   end

   // Start a sweep on dut_a; with hold=1 start stays high and a second sweep is expected.
   task automatic run_a(input logic [2:0] m, input logic [15:0] t, input logic [4:0] o,
                        input logic [15:0] mm, input logic p, input bit hold);
      exp_t e;
      @(negedge clk);
      mode    = m;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      e.tt = t; e.ones = o; e.cyc = cyc + 16; e.mm = mm; e.pass = p;
      q_a.push_back(e);
      if (hold) begin
         e.cyc = cyc + 34;
         q_a.push_back(e);
      end else begin
         start_a = 1'b0;
      end
   endtask

   task automatic wait_a();
      for (int i = 0; i < 300 && q_a.size() != 0; i++) @(negedge clk);
      check("a_sweep_timeout", 32'(q_a.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_idx_a(input logic [3:0] v);
      for (int i = 0; i < 60 && !(busy_a && {w_a, x_a, y_a, z_a} == v); i++) @(negedge clk);
      check("a_reach_idx", 32'({w_a, x_a, y_a, z_a}), 32'(v));
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 3'd0;
`ifdef TT_SWEEP_CMP_EN
      expected_a = '0; expected_b = '0;
`endif
      repeat (3) @(negedge clk);
      check("rst_a_outs", 32'({w_a, x_a, y_a, z_a, busy_a, done_a, tt_a, ones_a}), 32'd0);
      check("rst_b_outs", 32'({w_b, x_b, y_b, z_b, busy_b, done_b, tt_b, ones_b}), 32'd0);
`ifdef TT_SWEEP_CMP_EN
      check("rst_a_cmp", 32'({mismatch_a, pass_a}), 32'd0);
`endif
      rst_n = 1'b1;

      // f = w&x
      run_a(3'd0, 16'hF000, 5'd4, 16'hF000, 1'b0, 1'b0);
      wait_a();
      repeat (3) @(negedge clk);
      check("a_hold_wxyz", 32'({w_a, x_a, y_a, z_a}), 32'hF);
      check("a_hold_tt", 32'(tt_a), 32'hF000);
      check("a_idle_busy", 32'(busy_a), 32'd0);

      // SETTLE=3, f = z
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      e.tt = 16'hAAAA; e.ones = 5'd8; e.cyc = cyc + 48; e.mm = '0; e.pass = 1'b0;
      q_b.push_back(e);
      start_b = 1'b0;
      for (int i = 0; i < 300 && q_b.size() != 0; i++) @(negedge clk);
      check("b_sweep_timeout", 32'(q_b.size()), 32'd0);

      // all ones, then all zeros
      run_a(3'd1, 16'hFFFF, 5'd16, 16'hFFFF, 1'b0, 1'b0);
      wait_a();
      run_a(3'd2, 16'h0000, 5'd0, 16'h0000, 1'b1, 1'b0);
      wait_a();

      // start during SETTLE is ignored
      run_a(3'd0, 16'hF000, 5'd4, 16'hF000, 1'b0, 1'b0);
      wait_idx_a(4'd5);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_a();
      repeat (20) @(negedge clk);

      // reset mid-sweep discards partial table
      run_a(3'd1, 16'hFFFF, 5'd16, 16'hFFFF, 1'b0, 1'b0);
      wait_idx_a(4'd7);
      rst_n = 1'b0;
      #1;
      check("midrst_tt", 32'(tt_a), 32'd0);
      check("midrst_ones", 32'(ones_a), 32'd0);
      check("midrst_state", 32'({busy_a, done_a, w_a, x_a, y_a, z_a}), 32'd0);
      void'(q_a.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      run_a(3'd3, 16'h00FF, 5'd8, 16'h00FF, 1'b0, 1'b0);
      wait_a();

      // start held high: back-to-back sweeps
      run_a(3'd1, 16'hFFFF, 5'd16, 16'hFFFF, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      start_a = 1'b0;
      wait_a();

      // f = x^z against golden tables
`ifdef TT_SWEEP_CMP_EN
      expected_a = 16'h5A5A;
`endif
      run_a(3'd4, 16'h5A5A, 5'd8, 16'h0000, 1'b1, 1'b0);
      wait_a();
`ifdef TT_SWEEP_CMP_EN
      expected_a = 16'h5A5B;
`endif
      run_a(3'd4, 16'h5A5A, 5'd8, 16'h0001, 1'b0, 1'b0);
      wait_a();

      check("a_queue_drained", 32'(q_a.size()), 32'd0);
      check("b_queue_drained", 32'(q_b.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
